// File: rtl/uart_rx.sv
// 8N1 UART receiver: three-flop line conditioning, mid-bit sampling, and a
// one-cycle po_flag / frame_err strobe per received frame.
module uart_rx #(
  parameter logic [29:0] UART_BPS = 30'd9600,
  parameter logic [29:0] CLK_FREQ = 30'd50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);

  localparam logic [15:0] BAUD_CNT_MAX = 16'(CLK_FREQ / UART_BPS);
  localparam logic [15:0] BAUD_MID     = {1'b0, BAUD_CNT_MAX[15:1]};

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic        rx_s1;
  logic        rx_s2;
  logic        rx_s3;
  logic [1:0]  state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic        rx_fall;
  logic        mid;

  // Line conditioning: rx_s2 is the synchronized line, rx_s3 its previous value
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign rx_fall = rx_s3 & ~rx_s2;
  assign mid     = (baud_cnt == BAUD_MID) && (state != IDLE);

  // Bit timing: counter restarts from 0 the cycle the FSM leaves IDLE
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      baud_cnt <= 16'd0;
    end else if (state == IDLE || baud_cnt == BAUD_CNT_MAX - 16'd1) begin
      baud_cnt <= 16'd0;
    end else begin
      baud_cnt <= baud_cnt + 16'd1;
    end
  end

  // Frame FSM; leaving STOP at mid-bit leaves half a bit to catch the next start
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'h00;
      po_data   <= 8'h00;
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      po_flag   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_fall) begin
            state <= START;
          end
        end
        START: begin
          if (mid) begin
            if (!rx_s2) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end else begin
              state <= IDLE;
            end
          end
        end
        DATA: begin
          if (mid) begin
            shift_reg[bit_cnt] <= rx_s2;
            bit_cnt            <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state <= STOP;
            end
          end
        end
        STOP: begin
          if (mid) begin
            state <= IDLE;
            if (rx_s2) begin
              po_data <= shift_reg;
              po_flag <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 32 clocks per bit: directed frames push the
// expected strobe (kind, byte, cycle) and a monitor pops it on every strobe.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CLK_NS  = 10;
  localparam int DIV     = 32;
  localparam int BIT_NS  = DIV * CLK_NS;
  localparam int LAT     = 3 + DIV / 2 + 9 * DIV + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] po_data;
  logic       po_flag;
  logic       frame_err;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] last_data = 8'h00;
  exp_t       sb[$];

  uart_rx #(
    .UART_BPS(30'd100_000),
    .CLK_FREQ(30'd3_200_000)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .rx       (rx),
    .po_data  (po_data),
    .po_flag  (po_flag),
    .frame_err(frame_err)
  );

  always #(CLK_NS / 2) sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Caller must be on a falling clock edge when timing is checked
  task automatic send(input logic [7:0] d, input bit stop, input int bit_ns, input bit timed);
    exp_t e;
    e.err  = !stop;
    e.data = stop ? d : last_data;
    e.cyc  = timed ? cyc + LAT : -1;
    if (stop) last_data = d;
    sb.push_back(e);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop;
    #(bit_ns);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * DIV) @(negedge sys_clk);
  endtask

  initial begin
    exp_t e;
    int   c;
    int   waited;

    fork
      forever begin
        @(negedge sys_clk);
        if (po_flag && frame_err) begin
          chk("flag_and_err_together", 32'd1, 32'd0);
        end
        if (sys_rst && (po_flag || frame_err)) begin
          if (sb.size() == 0) begin
            chk("unexpected_strobe", {30'd0, frame_err, po_flag}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("strobe_kind_err", {31'd0, frame_err}, {31'd0, e.err});
            chk("strobe_kind_flag", {31'd0, po_flag}, {31'd0, !e.err});
            chk("po_data", {24'd0, po_data}, {24'd0, e.data});
            if (e.cyc >= 0) chk("strobe_cycle", cyc, e.cyc);
          end
        end
      end
    join_none

    // Reset values
    repeat (4) @(negedge sys_clk);
    chk("rst_po_data", {24'd0, po_data}, 32'd0);
    chk("rst_po_flag", {31'd0, po_flag}, 32'd0);
    chk("rst_frame_err", {31'd0, frame_err}, 32'd0);
    sys_rst = 1'b1;
    idle_bits(2);

    // Single frame with exact latency
    send(8'hA5, 1'b1, BIT_NS, 1'b1);
    idle_bits(2);

    // Back-to-back frames, no idle gap
    send(8'h00, 1'b1, BIT_NS, 1'b1);
    send(8'hFF, 1'b1, BIT_NS, 1'b1);
    send(8'h55, 1'b1, BIT_NS, 1'b1);
    idle_bits(2);

    // Framing error, stuck-low line, then recovery
    send(8'h3C, 1'b0, BIT_NS, 1'b1);
    repeat (3000) @(negedge sys_clk);
    idle_bits(3);
    send(8'h3C, 1'b1, BIT_NS, 1'b1);
    idle_bits(2);

    // Short start glitch is rejected at the start-bit midpoint
    c = cyc;
    rx = 1'b0;
    repeat (10) @(negedge sys_clk);
    rx = 1'b1;
    repeat (9) @(negedge sys_clk);
    chk("glitch_state_start", {30'd0, dut.state}, {30'd0, dut.START});
    @(negedge sys_clk);
    chk("glitch_state_idle", {30'd0, dut.state}, {30'd0, dut.IDLE});
    chk("glitch_cycle", cyc, c + 3 + DIV / 2 + 1);
    idle_bits(2);

    // Reset asserted during bit 4 of 8'h81
    rx = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 0);
      #(BIT_NS);
    end
    rx = 1'b0;
    #(BIT_NS / 2);
    sys_rst = 1'b0;
    rx = 1'b1;
    last_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    chk("midrst_po_data", {24'd0, po_data}, 32'd0);
    chk("midrst_po_flag", {31'd0, po_flag}, 32'd0);
    chk("midrst_frame_err", {31'd0, frame_err}, 32'd0);
    sys_rst = 1'b1;
    idle_bits(12);
    chk("after_rst_po_data", {24'd0, po_data}, 32'd0);
    send(8'h81, 1'b1, BIT_NS, 1'b1);
    idle_bits(2);

    // Line low across reset release: start detected, ends in framing error
    sys_rst = 1'b0;
    rx = 1'b0;
    last_data = 8'h00;
    e.err = 1'b1;
    e.data = 8'h00;
    e.cyc = -1;
    sb.push_back(e);
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    repeat (12 * DIV) @(negedge sys_clk);
    idle_bits(3);

    // Baud mismatch of about +/-4%
    send(8'h96, 1'b1, 333, 1'b0);
    idle_bits(2);
    send(8'hC3, 1'b1, 307, 1'b0);
    idle_bits(2);

    waited = 0;
    while (sb.size() != 0 && waited < 2000) begin
      @(negedge sys_clk);
      waited++;
    end
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver that pairs with the team's UART transmitter. It recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit) from the `rx` line and presents each byte as `po_data` with a single-cycle `po_flag` strobe. A framing check raises `frame_err` instead. It sits between the board UART pin and the byte-consuming logic, with the same `pi_data`/`pi_flag`-style byte handshake as the transmit side, mirrored.

## Interface
- `UART_BPS`, default 30'd9600: line baud rate.
- `CLK_FREQ`, default 30'd50_000_000: `sys_clk` frequency in Hz.
- `BAUD_CNT_MAX` (derived, not overridable): `CLK_FREQ/UART_BPS`, integer division; 5208 at defaults. Must be ≤ 65535 and ≥ 8.
- `sys_clk`, input, 1: clock, rising-edge.
- `sys_rst`, input, 1: reset, asynchronous, active-low.
- `rx`, input, 1: serial line, asynchronous to `sys_clk`, idle high.
- `po_data`, output, 8: last correctly framed byte; holds until the next valid frame.
- `po_flag`, output, 1: one-cycle pulse, `po_data` valid in the same cycle.
- `frame_err`, output, 1: one-cycle pulse when the stop bit is sampled low.

## Operation
- Input conditioning: three flops `rx_s1`→`rx_s2`→`rx_s3`, all reset to 1. `rx_s2` is the synchronized line. Falling edge = `rx_s3 & ~rx_s2`.
- `baud_cnt` is 16 bits. It is held at 0 in IDLE. In every other state it counts 0..`BAUD_CNT_MAX`-1 and wraps to 0.
- Sample strobe `mid` = (`baud_cnt` == `BAUD_CNT_MAX`/2) and state ≠ IDLE. Every line decision is made only on `mid`.
- IDLE: on falling edge → START; `baud_cnt` is already 0.
- START: on `mid`, if `rx_s2`==0 → DATA with `bit_cnt`=0. If `rx_s2`==1 → IDLE (glitch rejected, no output pulse).
- DATA: on `mid`, shift `rx_s2` into `shift_reg` at bit[`bit_cnt`] (LSB first) and increment `bit_cnt`. On the `mid` that samples bit 7 (`bit_cnt`==7) → STOP. `bit_cnt` is 3 bits and never wraps inside a frame.
- STOP, on `mid`:
  - `rx_s2`==1: `po_data` ← `shift_reg`; `po_flag` pulses on the next cycle; → IDLE.
  - `rx_s2`==0: `frame_err` pulses on the next cycle; `po_data` is unchanged; → IDLE.
- Returning to IDLE at mid-stop-bit lets a start bit that follows immediately be caught (back-to-back frames at full rate).
- Break or stuck-low line after a framing error: no falling edge occurs, so the block stays in IDLE until the line returns high and falls again.
- `po_flag` and `frame_err` are never high in the same cycle.
- There is no ready/backpressure. The consumer must capture `po_data` before the next `po_flag`. `po_data` is stable for at least 9.5 bit times after the pulse.

## Timing
- Reset values: `po_data`=8'h00, `po_flag`=0, `frame_err`=0, state=IDLE, `baud_cnt`=0, `bit_cnt`=0, `shift_reg`=0, sync flops=1.
- Assertion of reset mid-frame aborts immediately with no pulse.
- Let `rx` fall before edge E0. Then `rx_s2` is low after E1, and state=START after E2 (cycle T0).
- START `mid` occurs at T0+`BAUD_CNT_MAX`/2. Data bit k is sampled at T0+`BAUD_CNT_MAX`/2+(k+1)·`BAUD_CNT_MAX`. The stop sample is at T0+`BAUD_CNT_MAX`/2+9·`BAUD_CNT_MAX`.
- `po_flag`/`frame_err` is high exactly one cycle, starting one cycle after the stop sample. At defaults that is T0+49477 (2604+46872+1).
- Line low across reset release: sync flops go 1→0, so a start is detected. If the line stays low, the frame ends with `frame_err`=1 and `po_flag`=0.
- Start pulse shorter than `BAUD_CNT_MAX`/2 cycles: rejected in START, no output.
- Tolerance: sampling at mid-bit gives ±~4.5% total clock/baud mismatch margin over 10 bits.

## Test plan
- Defaults; send 8'hA5 at exactly 5208 clk/bit -> `po_flag` for exactly 1 cycle at T0+49477, `po_data`=8'hA5, `frame_err`=0.
- Back-to-back 8'h00, 8'hFF, 8'h55 with no idle gap -> three `po_flag` pulses 52080 cycles apart, values in order.
- Frame 8'h3C with stop bit driven low -> `frame_err` pulse, no `po_flag`, `po_data` keeps previous value. Line then held low 100k cycles -> no further pulses. Line released and a valid 8'h3C sent -> `po_flag`, `po_data`=8'h3C.
- 1000-cycle low glitch on idle line -> no `po_flag`/`frame_err`; state back to IDLE at T0+2604.
- `sys_rst` low during bit 4 of a frame, then released with the line high -> no pulse, all outputs at reset values. The next valid 8'h81 is received correctly.
- Transmitter at 5208±4% clk/bit sending 8'h96 -> received correctly; UART_BPS=115200 (`BAUD_CNT_MAX`=434) sending 8'hC3 -> received correctly.
